bank_sequencer: RTL and testbench

BANK_SEQUENCER -- requirements
Module: bank_sequencer

---
 rtl/bank_sequencer.sv | 154 +++++++++++++++
 tb/tb_bank_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_sequencer.sv
// Streams BANK_LEN-digit banks from a synchronous digit ROM to an evaluator with
// ready/valid handshaking, and accumulates the per-bank results into a 32-bit score.
module bank_sequencer #(
   parameter int NUM_BANKS = 200,
   parameter int BANK_LEN  = 100,
   parameter int ADDR_W    = 15,
   parameter int RES_W     = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_data,
   output logic              dig_valid,
   output logic [3:0]        dig_data,
   output logic              dig_last,
   input  logic              dig_ready,
   input  logic              res_valid,
   input  logic [RES_W-1:0]  res_value,
   output logic [31:0]       score,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W  = $clog2(BANK_LEN + 1);
   localparam int BANK_W = $clog2(NUM_BANKS + 1);

   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT_RES, S_ACCUM, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   rd_cnt;
   logic [BANK_W-1:0]  bank_idx;
   logic [ADDR_W-1:0]  addr_q;
   logic               rd_vld_p1, rd_last_p1;
   logic               skid_vld, skid_last;
   logic [3:0]         skid_data;
   logic               out_vld, out_last;
   logic [3:0]         out_data;
   logic [31:0]        res_cap;
   logic [31:0]        score_q;
   logic               err_q;

   logic               start_go, xfer, out_take, skid_load, issue, issue_last, room;
   logic [1:0]         occ;

   assign start_go   = start && (state_q == S_IDLE || state_q == S_DONE);
   assign xfer       = out_vld && dig_ready;
   assign out_take   = !out_vld || xfer;
   assign skid_load  = rd_vld_p1 && (!out_take || skid_vld);

   // A new read may only be issued if its data is guaranteed a slot next cycle,
   // even if the evaluator stalls: at most one digit may remain held after this edge.
   assign occ        = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_vld_p1};
   assign room       = (occ - {1'b0, xfer}) <= 2'd1;
   assign issue      = (state_q == S_STREAM) && (rd_cnt != CNT_W'(BANK_LEN)) && room;
   assign issue_last = (rd_cnt == CNT_W'(BANK_LEN - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE:     if (start) state_d = S_STREAM;
         S_STREAM: begin
            busy = 1'b1;
            if (xfer && out_last) state_d = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            busy = 1'b1;
            if (res_valid) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            busy    = 1'b1;
            state_d = (bank_idx == BANK_W'(NUM_BANKS - 1)) ? S_DONE : S_STREAM;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_d = S_STREAM;
         end
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt    <= '0;
         bank_idx  <= '0;
         addr_q    <= '0;
         rd_vld_p1 <= 1'b0;
         skid_vld  <= 1'b0;
         out_vld   <= 1'b0;
         out_last  <= 1'b0;
         score_q   <= '0;
         err_q     <= 1'b0;
      end else if (start_go) begin
         rd_cnt    <= '0;
         bank_idx  <= '0;
         addr_q    <= '0;
         rd_vld_p1 <= 1'b0;
         skid_vld  <= 1'b0;
         out_vld   <= 1'b0;
         out_last  <= 1'b0;
         score_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         // p1: ROM read in flight, data appears on rom_data next cycle
         rd_vld_p1 <= issue;
         if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            rd_cnt <= rd_cnt + CNT_W'(1);
         end else if (state_q == S_ACCUM) begin
            rd_cnt <= '0;
         end
         if (state_q == S_ACCUM) begin
            bank_idx <= bank_idx + BANK_W'(1);
            score_q  <= score_q + res_cap;
         end
         // output stage refills from the skid first so digit order is preserved
         if (out_take) begin
            out_vld  <= skid_vld | rd_vld_p1;
            out_last <= skid_vld ? skid_last : (rd_vld_p1 & rd_last_p1);
         end
         skid_vld <= out_take ? (skid_vld & rd_vld_p1) : (skid_vld | rd_vld_p1);
         if ((rd_vld_p1 && rom_data > 4'd9) || (res_valid && state_q != S_WAIT_RES))
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      rd_last_p1 <= issue_last;
      if (out_take)
         out_data <= skid_vld ? skid_data : rom_data;
      if (skid_load) begin
         skid_data <= rom_data;
         skid_last <= rd_last_p1;
      end
      if (state_q == S_WAIT_RES && res_valid)
         res_cap <= 32'(res_value);
   end

   assign rom_addr  = addr_q;
   assign dig_valid = out_vld;
   assign dig_data  = out_data;
   assign dig_last  = out_last;
   assign score     = score_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bank_sequencer.sv
// Randomized bench for bank_sequencer: ROM and evaluator models, scoreboard of
// expected digit order and a plain-arithmetic score model.
module tb_bank_sequencer;

   localparam int NB = 2;
   localparam int BL = 4;
   localparam int AW = 4;
   localparam int RW = 7;

   logic          clk = 1'b0;
   logic          rst, start, dig_ready;
   logic [AW-1:0] rom_addr;
   logic [3:0]    rom_data;
   logic          dig_valid, dig_last;
   logic [3:0]    dig_data;
   logic          res_valid;
   logic [RW-1:0] res_value;
   logic [31:0]   score;
   logic          busy, done, err;

   int errors = 0;
   int checks = 0;

   logic [3:0] rom [0:15];
   int         rmode = 0;
   int         cyc = 0;
   int         exp_q[$];
   int         xfer_n = 0, last_n = 0, results = 0, last_cyc = 0;
   int         bank_d [BL];
   bit         prev_hold = 0, prev_l = 0;
   logic [3:0] prev_d = '0;
   bit         ev_pend = 0, ev_pulse = 0, spur = 0;
   int         ev_val = 0, ev_dly = 0;

   bank_sequencer #(.NUM_BANKS(NB), .BANK_LEN(BL), .ADDR_W(AW), .RES_W(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .dig_valid(dig_valid), .dig_data(dig_data), .dig_last(dig_last), .dig_ready(dig_ready),
      .res_valid(res_valid), .res_value(res_value), .score(score), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];
   always @(posedge clk) cyc <= cyc + 1;

   assign res_valid = ev_pulse | spur;
   assign res_value = RW'(ev_val);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // best two-digit joltage: pick digits i<j maximising 10*d[i]+d[j]
   function automatic int jolt(input int d[BL]);
      int best = 0;
      for (int i = 0; i < BL; i++)
         for (int j = i + 1; j < BL; j++)
            if (10 * d[i] + d[j] > best) best = 10 * d[i] + d[j];
      return best;
   endfunction

   initial begin
      dig_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0:       dig_ready = 1'b1;
            1:       dig_ready = ~dig_ready;
            2:       dig_ready = 1'($urandom_range(0, 1));
            default: dig_ready = ($urandom_range(0, 3) == 0);
         endcase
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         ev_pulse = 1'b0;
         if (!rst) ev_pend = 1'b0;
         else if (ev_pend) begin
            if (ev_dly == 0) begin
               ev_pulse = 1'b1;
               ev_pend  = 1'b0;
            end else ev_dly--;
         end
      end
   end

   always @(negedge clk) begin
      int pos, e;
      if (!rst) prev_hold = 1'b0;
      else begin
         if (busy) chk("rd_ahead", 32'(rom_addr) > (results + 1) * BL, 0);
         if (prev_hold) begin
            chk("hold_valid", dig_valid, 1);
            chk("hold_data", dig_data, prev_d);
            chk("hold_last", dig_last, prev_l);
         end
         prev_hold = dig_valid && !dig_ready;
         prev_d    = dig_data;
         prev_l    = dig_last;
         if (dig_valid && dig_ready) begin
            pos = xfer_n % BL;
            e   = -1;
            chk("xfer_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("dig_data", dig_data, e);
            chk("dig_last", dig_last, pos == BL - 1);
            if (rmode == 0 && pos != 0) chk("stream_gap", cyc - last_cyc, 1);
            last_cyc    = cyc;
            bank_d[pos] = int'(dig_data);
            xfer_n++;
            if (dig_last) last_n++;
            if (pos == BL - 1) begin
               ev_val  = jolt(bank_d);
               ev_dly  = $urandom_range(0, 3);
               ev_pend = 1'b1;
            end
         end
         if (ev_pulse) results++;
      end
   end

   task automatic load(input logic [31:0] v);
      for (int i = 0; i < NB * BL; i++) rom[i] = v[31 - 4 * i -: 4];
   endtask

   task automatic arm(output int exp_score, output bit exp_err);
      int d[BL];
      exp_score = 0;
      exp_err   = 1'b0;
      exp_q.delete();
      xfer_n  = 0;
      last_n  = 0;
      results = 0;
      for (int b = 0; b < NB; b++) begin
         for (int k = 0; k < BL; k++) begin
            d[k] = int'(rom[b * BL + k]);
            exp_q.push_back(d[k]);
            if (d[k] > 9) exp_err = 1'b1;
         end
         exp_score += jolt(d);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run(input string tag, input int mode, input bit inj);
      int exp_score;
      bit exp_err;
      rmode = mode;
      arm(exp_score, exp_err);
      pulse_start();
      for (int c = 0; c < 600 && !done; c++) begin
         @(posedge clk); #1;
         start = inj && busy && ($urandom_range(0, 5) == 0);
      end
      start = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_score"}, score, exp_score);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_xfers"}, xfer_n, NB * BL);
      chk({tag, "_lasts"}, last_n, NB);
      chk({tag, "_addr"}, rom_addr, NB * BL);
      chk({tag, "_leftover"}, exp_q.size(), 0);
   endtask

   initial begin
      int es;
      bit ee;
      rst   = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", dig_valid, 0);
      chk("rst_last", dig_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_score", score, 0);
      chk("rst_addr", rom_addr, 0);
      rst = 1'b1;

      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      chk("spur_idle_err", err, 1);
      chk("spur_idle_busy", busy, 0);

      load(32'h1234_9119);
      run("basic", 0, 0);
      chk("basic_133", score, 133);

      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      chk("spur_done_err", err, 1);
      chk("spur_done_done", done, 1);
      chk("spur_done_score", score, 133);

      run("toggle", 1, 0);
      run("random_bp", 2, 0);
      run("start_mid", 2, 1);
      run("slow_bp", 3, 1);

      rmode = 0;
      arm(es, ee);
      pulse_start();
      for (int c = 0; c < 100 && xfer_n < 3; c++) begin
         @(posedge clk); #1;
      end
      chk("midrst_reach", xfer_n, 3);
      #2 rst = 1'b0;
      #1;
      chk("midrst_valid", dig_valid, 0);
      chk("midrst_last", dig_last, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_score", score, 0);
      chk("midrst_addr", rom_addr, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         chk("post_rst_quiet", {busy, dig_valid}, 0);
      end
      run("after_rst", 0, 0);
      chk("after_rst_133", score, 133);

      load(32'h12A4_9119);
      run("bad_digit", 2, 0);
      chk("bad_digit_score", score, 203);

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < NB * BL; i++) rom[i] = 4'($urandom_range(0, 9));
         run("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
